apb_timer: RTL
==============

// Module: apb_timer
// PURPOSE
//  APB completer (slave) peripheral: 32-bit down-counting timer with prescaler, periodic/one-shot
//  modes and level interrupt. Sits behind the AHB-to-APB bridge on the APB side of the SoC and
//  answers PSEL/PENABLE accesses with programmable wait states, byte strobes and PSLVERR.
// PARAMETERS
//  ADDRWIDTH    16  APB address width; only PADDR[3:2] decoded, PADDR[ADDRWIDTH-1:4]!=0 -> error
//  WAIT_STATES  0   extra access-phase cycles with PREADY=0 (0..7)
//  PRIV_CTRL    1   1: write to CTRL with PPROT[0]=0 (unprivileged) -> PSLVERR, no update
// PORTS
//  PCLK      in   1   clock (single clock domain)
//  PRESETn   in   1   reset, synchronous, active-low
//  PSEL      in   1   completer select
//  PENABLE   in   1   access phase
//  PWRITE    in   1   1=write
//  PADDR     in   ADDRWIDTH  byte address (PADDR[1:0] ignored)
//  PWDATA    in   32  write data
//  PSTRB     in   4   write byte strobes
//  PPROT     in   3   protection; only PPROT[0] used
//  PRDATA    out  32  read data, valid when PREADY=1 in access phase, else 0
//  PREADY    out  1   transfer complete
//  PSLVERR   out  1   error, valid only with PREADY=1 in access phase, else 0
//  IRQ       out  1   INTSTAT.TF & CTRL.IE, registered
// BEHAVIOUR
//  Register map (word offsets): 0x0 CTRL [0]EN [1]IE [2]ONESHOT [15:8]PRESC, others RAZ/WI
//   0x4 LOAD (RW)  0x8 VALUE (RO)  0xC INTSTAT [0]TF (read; write-1-to-clear)
//  Reset: all registers 0, PRDATA=0, PREADY=0, PSLVERR=0, IRQ=0, wait counter 0, prescaler 0.
//  APB FSM: IDLE -> (PSEL&~PENABLE) SETUP -> ACCESS. ACCESS: wait counter counts WAIT_STATES
//   cycles with PREADY=0, then one cycle PREADY=1 with PRDATA/PSLVERR; return IDLE, or SETUP if
//   next PSEL&~PENABLE seen. PSEL dropped mid-ACCESS (protocol violation) -> IDLE, no update.
//   WAIT_STATES=0: PREADY=1 in the first ACCESS cycle (2-cycle transfer, zero waits).
//  Register update / read sample happen only in the PREADY=1 cycle; PSLVERR=1 suppresses update.
//  PSLVERR cases: write to VALUE; out-of-range PADDR; CTRL write unprivileged when PRIV_CTRL=1.
//   Reads of defined registers never error. PSTRB=0 write -> OKAY, no change.
//  Byte strobes: LOAD/CTRL bytes updated per PSTRB[i]; INTSTAT clear uses PWDATA[0] & PSTRB[0].
//  Write to LOAD also copies the new LOAD (post-strobe) into VALUE and resets the prescaler.
//  Prescaler: 8-bit counter; tick when EN and count==PRESC, then count<=0. PRESC=0 -> tick every
//   cycle. EN=0 holds prescaler at 0 and VALUE frozen.
//  On tick: VALUE!=0 -> VALUE-1. VALUE==0 -> TF<=1; periodic: VALUE<=LOAD; one-shot: EN<=0,
//   VALUE stays 0. LOAD=0 periodic -> TF set every tick.
//  Simultaneous: LOAD write beats tick decrement/reload; TF set beats W1C clear in same cycle;
//   CTRL write EN=0 in tick cycle -> tick still applied that cycle.
//  IRQ = registered (TF & IE): asserts 1 cycle after TF sets; deasserts 1 cycle after clear/IE=0.
//  Reset asserted mid-transfer: next cycle all state at reset values, PREADY=0.
// STRUCTURE
//  Shared package apb_timer_pkg: register offsets (CTRL/LOAD/VALUE/INTSTAT), CTRL bit indices,
//   APB FSM state enum (IDLE/SETUP/ACCESS).
//  One sub-module: apb_timer_prescaler (8-bit divide counter, en/clear in, tick out).
//  Top holds APB FSM, wait counter, register file, counter and IRQ logic.
// TESTING
//  1 WAIT_STATES=2: write LOAD=0x10 -> PREADY low 2 access cycles, high on 3rd; VALUE reads 0x10.
//  2 LOAD=3, PRESC=0, CTRL=EN|IE -> VALUE 3,2,1,0 on successive cycles; TF=1 next tick, IRQ one
//    cycle later; VALUE reloads 3; write INTSTAT=1 -> IRQ drops next cycle.
//  3 ONESHOT, LOAD=2, PRESC=1 -> tick every 2nd cycle; at expiry EN reads 0, VALUE stays 0, TF=1.
//  4 Errors: write VALUE, read PADDR=0x10, unprivileged CTRL write -> PSLVERR=1 with PREADY,
//    registers unchanged; read CTRL -> PSLVERR=0.
//  5 PSTRB=4'b0010 write LOAD=0xAABBCCDD over 0 -> LOAD=0x0000CC00; PSTRB=0 -> unchanged, OKAY.
//  6 W1C on same cycle as expiry -> TF stays 1; PRESETn=0 during ACCESS -> PREADY=0, regs 0.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register offsets, CTRL bit positions,
// APB completer FSM states and a byte-strobe merge helper.
package apb_timer_pkg;

    // Word offsets decoded from PADDR[3:2]
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_LOAD    = 2'd1;
    localparam logic [1:0] REG_VALUE   = 2'd2;
    localparam logic [1:0] REG_INTSTAT = 2'd3;

    // CTRL field positions
    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_IE        = 1;
    localparam int unsigned CTRL_ONESHOT   = 2;
    localparam int unsigned CTRL_PRESC_LSB = 8;
    localparam int unsigned CTRL_PRESC_MSB = 15;

    localparam int unsigned PRESC_W = 8;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    // Merge new write data into an old word, byte lane i taken from wdata when strb[i]
    function automatic logic [31:0] apply_strobe(input logic [31:0] old_word,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_timer_if.sv
// APB bus bundle between the bridge (master) and the timer completer (slave).
interface apb_timer_if #(
    parameter int unsigned ADDRWIDTH = 16
) ();

    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic [31:0]          PWDATA;
    logic [3:0]           PSTRB;
    logic [2:0]           PPROT;
    logic [31:0]          PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_timer_prescaler.sv
// Prescaler for the APB timer: counts 0..presc and emits a one-cycle tick on the
// terminal count. Held at zero while disabled or when cleared.
module apb_timer_prescaler
    import apb_timer_pkg::*;
(
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               en,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] count_q;

    assign tick = en & (count_q == presc);

    // Divide counter: wraps to zero on tick, held at zero when disabled or cleared
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            count_q <= '0;
        end else if (!en || clear || tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/apb_timer.sv
// APB timer completer: 32-bit down-counter with prescaler, periodic/one-shot
// modes, level IRQ, programmable wait states and PSLVERR on illegal accesses.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int unsigned ADDRWIDTH   = 16,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned PRIV_CTRL   = 1
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    apb_timer_if.slave  apb,
    output logic        IRQ
);

    localparam logic [2:0] WAIT_MAX = 3'(WAIT_STATES);

    apb_state_e state_q, state_d;
    logic [2:0] wcnt_q;

    logic               ctrl_en_q, ctrl_ie_q, ctrl_oneshot_q;
    logic [PRESC_W-1:0] ctrl_presc_q;
    logic [31:0]        load_q, value_q;
    logic               tf_q, irq_q;

    logic        in_access, xfer_done;
    logic [1:0]  reg_sel;
    logic        addr_err, wr_err, acc_err;
    logic        wr_commit, wr_ctrl, wr_load, wr_intstat;
    logic [31:0] load_new, rdata;
    logic        tick, expire;
    logic        unused_bits;

    // state_q records the phase seen on the previous edge: SETUP means the
    // last cycle was a setup cycle, so the current cycle is the first access cycle.
    assign in_access = (state_q != APB_IDLE) & apb.PSEL & apb.PENABLE;
    assign xfer_done = in_access & (wcnt_q == WAIT_MAX);

    assign reg_sel  = apb.PADDR[3:2];
    assign addr_err = |apb.PADDR[ADDRWIDTH-1:4];
    assign wr_err   = apb.PWRITE &
                      ((reg_sel == REG_VALUE) ||
                       ((PRIV_CTRL != 0) && (reg_sel == REG_CTRL) && !apb.PPROT[0]));
    assign acc_err  = addr_err | wr_err;

    assign wr_commit  = xfer_done & apb.PWRITE & ~acc_err;
    assign wr_ctrl    = wr_commit & (reg_sel == REG_CTRL);
    assign wr_load    = wr_commit & (reg_sel == REG_LOAD);
    assign wr_intstat = wr_commit & (reg_sel == REG_INTSTAT);

    assign load_new = apply_strobe(load_q, apb.PWDATA, apb.PSTRB);
    assign expire   = tick & (value_q == '0);
    assign IRQ      = irq_q;

    assign unused_bits = ^{apb.PADDR[1:0], apb.PPROT[2:1]};

    apb_timer_prescaler u_presc (
        .HCLK    (PCLK),
        .HRESETn (PRESETn),
        .en      (ctrl_en_q),
        .clear   (wr_load),
        .presc   (ctrl_presc_q),
        .tick    (tick)
    );

    // APB FSM state register
    always_ff @(posedge PCLK) begin
        if (!PRESETn) state_q <= APB_IDLE;
        else          state_q <= state_d;
    end

    // APB FSM next-state: a dropped PSEL or a fresh setup aborts the transfer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            APB_IDLE: begin
                if (apb.PSEL && !apb.PENABLE) state_d = APB_SETUP;
            end
            APB_SETUP, APB_ACCESS: begin
                if (!apb.PSEL)         state_d = APB_IDLE;
                else if (!apb.PENABLE) state_d = APB_SETUP;
                else if (xfer_done)    state_d = APB_IDLE;
                else                   state_d = APB_ACCESS;
            end
            default: state_d = APB_IDLE;
        endcase
    end

    // APB FSM outputs: response only in the completing access cycle
    always_comb begin
        apb.PREADY  = xfer_done;
        apb.PSLVERR = xfer_done & acc_err;
        apb.PRDATA  = (xfer_done && !apb.PWRITE && !acc_err) ? rdata : '0;
    end

    // Wait-state counter: counts stalled access cycles, cleared otherwise
    always_ff @(posedge PCLK) begin
        if (!PRESETn)                    wcnt_q <= '0;
        else if (in_access && !xfer_done) wcnt_q <= wcnt_q + 3'd1;
        else                             wcnt_q <= '0;
    end

    // Read multiplexer over the register map
    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            REG_CTRL: begin
                rdata[CTRL_EN]      = ctrl_en_q;
                rdata[CTRL_IE]      = ctrl_ie_q;
                rdata[CTRL_ONESHOT] = ctrl_oneshot_q;
                rdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = ctrl_presc_q;
            end
            REG_LOAD:    rdata = load_q;
            REG_VALUE:   rdata = value_q;
            REG_INTSTAT: rdata[0] = tf_q;
            default:     rdata = '0;
        endcase
    end

    // CTRL register: byte-strobed writes; one-shot expiry clears EN unless written this cycle
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            ctrl_en_q      <= 1'b0;
            ctrl_ie_q      <= 1'b0;
            ctrl_oneshot_q <= 1'b0;
            ctrl_presc_q   <= '0;
        end else begin
            if (expire && ctrl_oneshot_q) ctrl_en_q <= 1'b0;
            if (wr_ctrl && apb.PSTRB[0]) begin
                ctrl_en_q      <= apb.PWDATA[CTRL_EN];
                ctrl_ie_q      <= apb.PWDATA[CTRL_IE];
                ctrl_oneshot_q <= apb.PWDATA[CTRL_ONESHOT];
            end
            if (wr_ctrl && apb.PSTRB[1]) begin
                ctrl_presc_q <= apb.PWDATA[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
            end
        end
    end

    // LOAD and VALUE: a LOAD write overrides any decrement/reload in the same cycle
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            load_q  <= '0;
            value_q <= '0;
        end else begin
            if (wr_load) load_q <= load_new;
            if (wr_load) begin
                value_q <= load_new;
            end else if (tick) begin
                if (value_q != '0)        value_q <= value_q - 32'd1;
                else if (!ctrl_oneshot_q) value_q <= load_q;
            end
        end
    end

    // Timer flag and registered IRQ: a set on expiry wins over a W1C in the same cycle
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            tf_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (expire)                                           tf_q <= 1'b1;
            else if (wr_intstat && apb.PWDATA[0] && apb.PSTRB[0]) tf_q <= 1'b0;
            irq_q <= tf_q & ctrl_ie_q;
        end
    end

endmodule
